bp_cce_lite_responder: RTL and testbench
========================================

BP_CCE_LITE_RESPONDER -- requirements
Module: bp_cce_lite_responder

Interface
REQ-001 Parameter paddr_width_p, default 40, physical address width.
REQ-002 Parameter block_width_p, default 512, cache block data width.
REQ-003 Parameter ack_timeout_p, default 255, max cycles to wait for a coherence ack (used only with REQ-030).
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 reset_i  in  1  asynchronous, active-low reset.
REQ-006 lce_req_i  in  2x(1+paddr_width_p)  per-LCE request {excl, addr}; index 0 = icache LCE, 1 = dcache LCE.
REQ-007 lce_req_v_i  in  2  per-LCE request valid.
REQ-008 lce_req_yumi_o  out  2  one-hot consume strobe for the granted request.
REQ-009 mem_cmd_o  out  paddr_width_p  block-aligned read address; with mem_cmd_v_o out 1 / mem_cmd_ready_i in 1 (ready/valid).
REQ-010 mem_resp_i  in  block_width_p  fill data; with mem_resp_v_i in 1 / mem_resp_yumi_o out 1.
REQ-011 lce_cmd_o  out  1+2+paddr_width_p+block_width_p  {dst_lce, state, addr, data}; state 1 = shared, 2 = exclusive; with lce_cmd_v_o out 1 / lce_cmd_ready_i in 1.
REQ-012 lce_resp_i  in  1+paddr_width_p  coherence ack {src_lce, addr}; with lce_resp_v_i in 1 / lce_resp_yumi_o out 1.
REQ-013 busy_o  out  1  high in any state other than READY.
REQ-014 error_o  out  1  sticky protocol error flag.

Function
REQ-015 The FSM SHALL have states READY, MEM_CMD, MEM_WAIT, LCE_CMD and ACK_WAIT, visited in that order per transaction.
REQ-016 READY: on any lce_req_v_i, grant round-robin (last-granted LCE loses ties), pulse the winner's lce_req_yumi_o for exactly one cycle, latch {lce, excl, addr with low log2(block_width_p/8) bits zeroed}, go to MEM_CMD.
REQ-017 Round-robin pointer SHALL update only on a grant; with a single requester it is granted regardless of the pointer.
REQ-018 MEM_CMD: mem_cmd_v_o=1 with latched addr; advance to MEM_WAIT in the cycle mem_cmd_ready_i=1.
REQ-019 MEM_WAIT: in the cycle mem_resp_v_i=1, assert mem_resp_yumi_o combinationally, latch data, go to LCE_CMD.
REQ-020 LCE_CMD: lce_cmd_v_o=1, lce_cmd_o={latched lce, excl?2:1, addr, data}, held stable until lce_cmd_ready_i=1, then go to ACK_WAIT.
REQ-021 ACK_WAIT: on lce_resp_v_i, assert lce_resp_yumi_o; if src_lce and addr match the latched values go to READY, else set error_o and still go to READY.
REQ-022 An lce_resp_v_i seen in any state other than ACK_WAIT SHALL be consumed and SHALL set error_o.
REQ-023 Minimum transaction latency with all handshakes ready: grant to lce_cmd_v_o = 3 cycles; grant to READY = 5 cycles.
REQ-024 Only one transaction in flight; lce_req_yumi_o=0 outside READY.
REQ-025 Valid outputs SHALL not depend combinationally on their own ready input.

Reset
REQ-026 Asserting reset_i at any time SHALL asynchronously force READY, clear error_o, set the round-robin pointer to LCE 1 (LCE 0 wins first), and drop all v/yumi outputs to 0.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no further handshake.
REQ-028 Latched address/data SHALL reset to 0.

Configuration
REQ-029 Macro BP_CCE_LITE_ACK_TIMEOUT_EN selects the ACK_WAIT timeout.
REQ-030 Defined: a counter cleared on ACK_WAIT entry increments each ACK_WAIT cycle; when it reaches ack_timeout_p without an ack, set error_o and go to READY.
REQ-031 Undefined: no counter; ACK_WAIT waits indefinitely; ack_timeout_p is unused.

Verification
REQ-032 LCE0 req {excl=0, addr=0x8000_0044}, all ready -> mem_cmd_o=0x8000_0000; lce_cmd dst=0, state=1, 3 cycles after grant; ack -> READY 5 cycles after grant.
REQ-033 Both LCEs request in the same cycle after reset, held -> LCE0 served first, LCE1 next; repeat the pair -> LCE0 then LCE1 again (alternation).
REQ-034 lce_cmd_ready_i low 10 cycles -> lce_cmd_o stable all 10 cycles, one accept.
REQ-035 Ack with src_lce=1 for a dst=0 transaction -> error_o=1, FSM to READY, error held until reset.
REQ-036 Reset asserted in MEM_WAIT -> all valids 0 immediately; after release, new request served normally.
REQ-037 With BP_CCE_LITE_ACK_TIMEOUT_EN, ack_timeout_p=4, no ack -> error_o rises 4 cycles after ACK_WAIT entry; without the macro -> busy_o stays high.

Source files
------------

// File: rtl/bp_cce_lite_responder_if.sv
// Handshake bundle between the lite CCE responder and its LCEs / memory.
// Signal names follow the responder's point of view (_i into it, _o out of it).
interface bp_cce_lite_responder_if #(
    parameter int paddr_width_p = 40,
    parameter int block_width_p = 512
);
    logic [1:0][paddr_width_p:0]            lce_req_i;
    logic [1:0]                             lce_req_v_i;
    logic [1:0]                             lce_req_yumi_o;

    logic [paddr_width_p-1:0]               mem_cmd_o;
    logic                                   mem_cmd_v_o;
    logic                                   mem_cmd_ready_i;

    logic [block_width_p-1:0]               mem_resp_i;
    logic                                   mem_resp_v_i;
    logic                                   mem_resp_yumi_o;

    logic [2+paddr_width_p+block_width_p:0] lce_cmd_o;
    logic                                   lce_cmd_v_o;
    logic                                   lce_cmd_ready_i;

    logic [paddr_width_p:0]                 lce_resp_i;
    logic                                   lce_resp_v_i;
    logic                                   lce_resp_yumi_o;

    modport slave (
        input  lce_req_i, lce_req_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
               lce_cmd_ready_i, lce_resp_i, lce_resp_v_i,
        output lce_req_yumi_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o,
               lce_cmd_o, lce_cmd_v_o, lce_resp_yumi_o
    );

    modport master (
        output lce_req_i, lce_req_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
               lce_cmd_ready_i, lce_resp_i, lce_resp_v_i,
        input  lce_req_yumi_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o,
               lce_cmd_o, lce_cmd_v_o, lce_resp_yumi_o
    );
endinterface

// File: rtl/bp_cce_lite_responder.sv
// Single-transaction coherence responder for two LCEs: grant, fetch block, send cmd, await ack.
// Optional ACK_WAIT timeout enabled by defining BP_CCE_LITE_ACK_TIMEOUT_EN.
module bp_cce_lite_responder #(
    parameter int paddr_width_p = 40,
    parameter int block_width_p = 512,
    parameter int ack_timeout_p = 255
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    bp_cce_lite_responder_if.slave        bus_io,
    output logic                          busy_o,
    output logic                          error_o
);
    localparam int offset_w_lp = $clog2(block_width_p / 8);
    localparam logic [paddr_width_p-1:0] align_mask_lp = {paddr_width_p{1'b1}} << offset_w_lp;

    typedef enum logic [2:0] {READY, MEM_CMD, MEM_WAIT, LCE_CMD, ACK_WAIT} state_e;

    state_e                   state_q, state_d;
    logic                     lce_q, lce_d;
    logic                     excl_q, excl_d;
    logic                     last_q, last_d;
    logic                     error_q, error_d;
    logic [paddr_width_p-1:0] addr_q, addr_d;
    logic [block_width_p-1:0] data_q, data_d;

    logic [1:0]                     req_excl;
    logic [1:0][paddr_width_p-1:0]  req_addr;
    logic                           gnt_lce;
    logic                           ack_match;
    logic                           ack_timeout;
    logic [1:0]                     req_yumi;
    logic                           mem_cmd_v, mem_resp_yumi, lce_cmd_v;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_excl[gi] = bus_io.lce_req_i[gi][paddr_width_p];
        assign req_addr[gi] = bus_io.lce_req_i[gi][paddr_width_p-1:0] & align_mask_lp;
    end

    // Last-granted LCE loses a tie; a lone requester always wins.
    assign gnt_lce   = (&bus_io.lce_req_v_i) ? ~last_q : bus_io.lce_req_v_i[1];
    assign ack_match = (bus_io.lce_resp_i[paddr_width_p] == lce_q)
                    && (bus_io.lce_resp_i[paddr_width_p-1:0] == addr_q);

`ifdef BP_CCE_LITE_ACK_TIMEOUT_EN
    localparam int cnt_w_lp = $clog2(ack_timeout_p + 1);
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;

    // Held at zero outside ACK_WAIT, so it is already clear on entry.
    assign cnt_d       = (state_q == ACK_WAIT) ? cnt_q + cnt_w_lp'(1) : '0;
    assign ack_timeout = (cnt_q == cnt_w_lp'(ack_timeout_p - 1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(ack_timeout_p);
    assign ack_timeout    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= READY;
            lce_q   <= 1'b0;
            excl_q  <= 1'b0;
            last_q  <= 1'b1;
            error_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lce_q   <= lce_d;
            excl_q  <= excl_d;
            last_q  <= last_d;
            error_q <= error_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lce_d         = lce_q;
        excl_d        = excl_q;
        last_d        = last_q;
        error_d       = error_q;
        addr_d        = addr_q;
        data_d        = data_q;
        req_yumi      = 2'b00;
        mem_cmd_v     = 1'b0;
        mem_resp_yumi = 1'b0;
        lce_cmd_v     = 1'b0;

        // Acks arriving outside ACK_WAIT are swallowed but flagged.
        if (bus_io.lce_resp_v_i && state_q != ACK_WAIT) error_d = 1'b1;

        case (state_q)
            READY: begin
                if (reset_i && (|bus_io.lce_req_v_i)) begin
                    req_yumi[gnt_lce] = 1'b1;
                    lce_d             = gnt_lce;
                    last_d            = gnt_lce;
                    excl_d            = req_excl[gnt_lce];
                    addr_d            = req_addr[gnt_lce];
                    state_d           = MEM_CMD;
                end
            end
            MEM_CMD: begin
                mem_cmd_v = 1'b1;
                if (bus_io.mem_cmd_ready_i) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (bus_io.mem_resp_v_i) begin
                    mem_resp_yumi = 1'b1;
                    data_d        = bus_io.mem_resp_i;
                    state_d       = LCE_CMD;
                end
            end
            LCE_CMD: begin
                lce_cmd_v = 1'b1;
                if (bus_io.lce_cmd_ready_i) state_d = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (bus_io.lce_resp_v_i) begin
                    state_d = READY;
                    if (!ack_match) error_d = 1'b1;
                end else if (ack_timeout) begin
                    state_d = READY;
                    error_d = 1'b1;
                end
            end
            default: state_d = READY;
        endcase
    end

    assign bus_io.lce_req_yumi_o  = req_yumi;
    assign bus_io.mem_cmd_o       = addr_q;
    assign bus_io.mem_cmd_v_o     = mem_cmd_v;
    assign bus_io.mem_resp_yumi_o = mem_resp_yumi;
    assign bus_io.lce_cmd_o       = {lce_q, (excl_q ? 2'd2 : 2'd1), addr_q, data_q};
    assign bus_io.lce_cmd_v_o     = lce_cmd_v;
    assign bus_io.lce_resp_yumi_o = bus_io.lce_resp_v_i & reset_i;
    assign busy_o                 = (state_q != READY);
    assign error_o                = error_q;
endmodule

// File: tb/tb_bp_cce_lite_responder.sv
// Directed bench for bp_cce_lite_responder: handshakes driven cycle by cycle on the falling edge.
module tb_bp_cce_lite_responder;
    localparam int PAW  = 40;
    localparam int BW   = 512;
    localparam int TO   = 4;
    localparam int CMDW = 3 + PAW + BW;
    localparam logic [PAW-1:0] ALIGN = ~40'h3f;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy, err;
    logic exp_err = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bp_cce_lite_responder_if #(.paddr_width_p(PAW), .block_width_p(BW)) bus ();

    bp_cce_lite_responder #(
        .paddr_width_p(PAW),
        .block_width_p(BW),
        .ack_timeout_p(TO)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus_io  (bus),
        .busy_o  (busy),
        .error_o (err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] blk(input logic [63:0] hi, input logic [63:0] lo);
        return {hi, {6{64'hCAFE_F00D_0BAD_BEEF}}, lo};
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        bus.lce_req_v_i  = 2'b11;
        bus.lce_resp_v_i = 1'b1;
        bus.mem_resp_v_i = 1'b1;
        #1;
        check_val({tag, ".busy"},      64'(busy), 64'd0);
        check_val({tag, ".err"},       64'(err), 64'd0);
        check_val({tag, ".req_yumi"},  64'(bus.lce_req_yumi_o), 64'd0);
        check_val({tag, ".mem_cmd_v"}, 64'(bus.mem_cmd_v_o), 64'd0);
        check_val({tag, ".mem_cmd"},   64'(bus.mem_cmd_o), 64'd0);
        check_val({tag, ".lce_cmd_v"}, 64'(bus.lce_cmd_v_o), 64'd0);
        check_val({tag, ".resp_yumi"}, 64'(bus.mem_resp_yumi_o), 64'd0);
        check_val({tag, ".ack_yumi"},  64'(bus.lce_resp_yumi_o), 64'd0);
        @(negedge clk);
        bus.lce_req_v_i  = 2'b00;
        bus.lce_resp_v_i = 1'b0;
        bus.mem_resp_v_i = 1'b0;
        #1;
        reset_n = 1'b1;
        exp_err = 1'b0;
        $display("txn %s: reset applied", tag);
    endtask

    // One READY cycle: present requests, check the consume strobe and status.
    task automatic grant(input string tag, input logic [1:0] req_v, input logic [1:0] exp_yumi);
        @(negedge clk);
        bus.lce_resp_v_i = 1'b0;
        bus.lce_req_v_i  = req_v;
        #1;
        check_val({tag, ".req_yumi"}, 64'(bus.lce_req_yumi_o), 64'(exp_yumi));
        check_val({tag, ".idle_busy"}, 64'(busy), 64'd0);
        check_val({tag, ".err"}, 64'(err), 64'(exp_err));
    endtask

    // ack_mode: 0 good ack, 1 wrong src, 2 wrong addr, 3 no ack (returns in ACK_WAIT entry cycle)
    task automatic serve(input string tag, input logic lce, input logic excl,
                         input logic [PAW-1:0] addr, input logic [BW-1:0] data,
                         input int stall, input int ack_mode);
        logic [PAW-1:0]  al;
        logic [CMDW-1:0] exp_cmd;
        logic [PAW:0]    ack;
        al      = addr & ALIGN;
        exp_cmd = {lce, (excl ? 2'd2 : 2'd1), al, data};

        @(negedge clk);
        bus.lce_req_v_i[lce] = 1'b0;
        #1;
        check_val({tag, ".mem_cmd_v"}, 64'(bus.mem_cmd_v_o), 64'd1);
        check_val({tag, ".mem_cmd"},   64'(bus.mem_cmd_o), 64'(al));
        check_val({tag, ".no_yumi"},   64'(bus.lce_req_yumi_o), 64'd0);
        check_val({tag, ".busy"},      64'(busy), 64'd1);

        @(negedge clk);
        bus.mem_resp_i   = data;
        bus.mem_resp_v_i = 1'b1;
        #1;
        check_val({tag, ".resp_yumi"},  64'(bus.mem_resp_yumi_o), 64'd1);
        check_val({tag, ".mem_cmd_v0"}, 64'(bus.mem_cmd_v_o), 64'd0);

        @(negedge clk);
        bus.mem_resp_v_i    = 1'b0;
        bus.lce_cmd_ready_i = (stall == 0);
        #1;
        check_val({tag, ".lce_cmd_v"}, 64'(bus.lce_cmd_v_o), 64'd1);
        check_val({tag, ".dst"},       64'(bus.lce_cmd_o[CMDW-1]), 64'(lce));
        check_val({tag, ".state"},     64'(bus.lce_cmd_o[CMDW-2 -: 2]), (excl ? 64'd2 : 64'd1));
        check_val({tag, ".cmd_addr"},  64'(bus.lce_cmd_o[BW+PAW-1 -: PAW]), 64'(al));
        check_val({tag, ".data_lo"},   bus.lce_cmd_o[63:0], data[63:0]);
        check_val({tag, ".data_hi"},   bus.lce_cmd_o[BW-1 -: 64], data[BW-1 -: 64]);

        for (int i = 1; i <= stall; i++) begin
            @(negedge clk);
            bus.lce_cmd_ready_i = (i == stall);
            #1;
            check_val({tag, ".cmd_stable"}, 64'(bus.lce_cmd_v_o && (bus.lce_cmd_o == exp_cmd)), 64'd1);
        end

        ack = {lce, al};
        if (ack_mode == 1) ack[PAW] = ~lce;
        if (ack_mode == 2) ack = {lce, al ^ 40'h40};
        @(negedge clk);
        bus.lce_resp_i   = ack;
        bus.lce_resp_v_i = (ack_mode != 3);
        #1;
        check_val({tag, ".one_accept"}, 64'(bus.lce_cmd_v_o), 64'd0);
        check_val({tag, ".ack_busy"},   64'(busy), 64'd1);
        check_val({tag, ".ack_yumi"},   64'(bus.lce_resp_yumi_o), 64'(ack_mode != 3));
        if (ack_mode == 1 || ack_mode == 2) exp_err = 1'b1;
        $display("txn %s: lce=%0d excl=%0d addr=0x%0h ack_mode=%0d", tag, lce, excl, al, ack_mode);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.lce_req_i       = '0;
        bus.lce_req_v_i     = 2'b00;
        bus.mem_cmd_ready_i = 1'b1;
        bus.mem_resp_i      = '0;
        bus.mem_resp_v_i    = 1'b0;
        bus.lce_cmd_ready_i = 1'b1;
        bus.lce_resp_i      = '0;
        bus.lce_resp_v_i    = 1'b0;

        do_reset("reset");

        // Simultaneous requests alternate, LCE0 first after reset
        bus.lce_req_i[0] = {1'b0, 40'h00_1234_5678};
        bus.lce_req_i[1] = {1'b1, 40'h00_ABCD_EF80};
        grant("rr0", 2'b11, 2'b01);
        serve("rr0", 1'b0, 1'b0, 40'h00_1234_5678, blk(64'h1111, 64'hA0A0), 0, 0);
        grant("rr1", 2'b10, 2'b10);
        serve("rr1", 1'b1, 1'b1, 40'h00_ABCD_EF80, blk(64'h2222, 64'hB1B1), 0, 0);
        grant("rr2", 2'b11, 2'b01);
        serve("rr2", 1'b0, 1'b0, 40'h00_1234_5678, blk(64'h3333, 64'hC2C2), 0, 0);
        grant("rr3", 2'b10, 2'b10);
        serve("rr3", 1'b1, 1'b1, 40'h00_ABCD_EF80, blk(64'h4444, 64'hD3D3), 0, 0);

        // Basic read, then a lone requester granted against the pointer
        bus.lce_req_i[0] = {1'b0, 40'h00_8000_0044};
        grant("basic", 2'b01, 2'b01);
        serve("basic", 1'b0, 1'b0, 40'h00_8000_0044, blk(64'hFEED, 64'h0123_4567_89AB_CDEF), 0, 0);
        grant("solo0", 2'b01, 2'b01);
        serve("solo0", 1'b0, 1'b0, 40'h00_8000_0044, blk(64'h5555, 64'h6666), 0, 0);

        // LCE command back-pressure for 10 cycles
        bus.lce_req_i[1] = {1'b1, 40'hFF_5555_557F};
        grant("stall", 2'b10, 2'b10);
        serve("stall", 1'b1, 1'b1, 40'hFF_5555_557F, blk(64'h7777, 64'h8888), 10, 0);

        // Wrong-source ack: error sticks until reset
        grant("badsrc", 2'b01, 2'b01);
        serve("badsrc", 1'b0, 1'b0, 40'h00_8000_0044, blk(64'h9999, 64'hAAAA), 0, 1);
        for (int i = 0; i < 3; i++) grant("err_hold", 2'b00, 2'b00);
        grant("after_err", 2'b01, 2'b01);
        serve("after_err", 1'b0, 1'b0, 40'h00_8000_0044, blk(64'hBBBB, 64'hCCCC), 0, 0);
        grant("err_still", 2'b00, 2'b00);
        do_reset("rst_err");

        // Wrong-address ack
        grant("badaddr", 2'b10, 2'b10);
        serve("badaddr", 1'b1, 1'b1, 40'hFF_5555_557F, blk(64'hDDDD, 64'hEEEE), 0, 2);
        grant("badaddr_chk", 2'b00, 2'b00);
        do_reset("rst_addr");

        // Stray ack while idle
        @(negedge clk);
        bus.lce_resp_i   = {1'b0, 40'h00_8000_0040};
        bus.lce_resp_v_i = 1'b1;
        #1;
        check_val("stray.ack_yumi", 64'(bus.lce_resp_yumi_o), 64'd1);
        check_val("stray.err_before", 64'(err), 64'd0);
        exp_err = 1'b1;
        grant("stray", 2'b00, 2'b00);
        do_reset("rst_stray");

        // Reset while waiting on memory abandons the transaction
        grant("abort", 2'b01, 2'b01);
        @(negedge clk);
        bus.lce_req_v_i = 2'b00;
        #1;
        check_val("abort.mem_cmd_v", 64'(bus.mem_cmd_v_o), 64'd1);
        @(negedge clk);
        #1;
        check_val("abort.wait_yumi", 64'(bus.mem_resp_yumi_o), 64'd0);
        check_val("abort.wait_busy", 64'(busy), 64'd1);
        do_reset("abort_rst");
        grant("post_abort", 2'b01, 2'b01);
        serve("post_abort", 1'b0, 1'b0, 40'h00_8000_0044, blk(64'h1212, 64'h3434), 0, 0);

        // Missing ack
        grant("noack", 2'b10, 2'b10);
        serve("noack", 1'b1, 1'b1, 40'hFF_5555_557F, blk(64'h5656, 64'h7878), 0, 3);
`ifdef BP_CCE_LITE_ACK_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            #1;
            check_val("timeout.err", 64'(err), 64'(i == TO));
            check_val("timeout.busy", 64'(busy), 64'(i != TO));
        end
`else
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            check_val("noto.busy", 64'(busy), 64'd1);
            check_val("noto.err", 64'(err), 64'd0);
        end
`endif
        do_reset("rst_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
